// File: rtl/hilo_md_ctrl.sv
// Multiply/divide sequencer and HI/LO register pair: 32-step shift-add multiply or
// restoring divide, sign fixup, then HI/LO commit, stalling dependent instructions meanwhile.
module hilo_md_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue,
  input  logic             mult_instrc,
  input  logic             multu_instrc,
  input  logic             div_instrc,
  input  logic             divu_instrc,
  input  logic             mthi_instrc,
  input  logic             mtlo_instrc,
  input  logic             mfhi_instrc,
  input  logic             mflo_instrc,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_SIGN = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opb;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic             any_flag;
  logic             op_signed;
  logic [WIDTH-1:0] abs_rs;
  logic [WIDTH-1:0] abs_rt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  assign busy     = (state != S_IDLE);
  assign any_flag = mult_instrc | multu_instrc | div_instrc | divu_instrc |
                    mthi_instrc | mtlo_instrc | mfhi_instrc | mflo_instrc;
  assign stall    = issue & busy & any_flag;
  assign mf_data  = mfhi_instrc ? hi : (mflo_instrc ? lo : '0);

  // Only reached for a multiply when mult/multu set, or for a divide when neither is set,
  // so this single flag follows the priority order in both branches.
  assign op_signed = mult_instrc | (~multu_instrc & div_instrc);
  assign abs_rs    = rs_data[WIDTH-1] ? -rs_data : rs_data;
  assign abs_rt    = rt_data[WIDTH-1] ? -rt_data : rt_data;

  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, opb};
  // Unsigned compare keeps divide-by-zero clean: every step subtracts zero, leaving
  // the quotient all ones and the dividend shifted back into the remainder.
  assign rem_ge   = (rem_sh >= {1'b0, opb});

  assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quot_fix = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_r ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (issue && !cancel) begin
          if (mult_instrc || multu_instrc) begin
            acc_hi   <= '0;
            acc_lo   <= op_signed ? abs_rs : rs_data;
            opb      <= op_signed ? abs_rt : rt_data;
            neg_q    <= op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= CW'(WIDTH);
            state    <= S_MUL;
          end else if (div_instrc || divu_instrc) begin
            acc_hi   <= '0;
            acc_lo   <= op_signed ? abs_rs : rs_data;
            opb      <= op_signed ? abs_rt : rt_data;
            neg_q    <= op_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r    <= op_signed & rs_data[WIDTH-1];
            is_div   <= 1'b1;
            div_zero <= (rt_data == '0);
            cnt      <= CW'(WIDTH);
            state    <= S_DIV;
          end else if (mthi_instrc) begin
            hi <= rs_data;
          end else if (mtlo_instrc) begin
            lo <= rs_data;
          end
        end
      end else if (cancel) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_MUL: begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_SIGN;
          end
          S_DIV: begin
            acc_hi <= rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], rem_ge};
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_SIGN;
          end
          default: begin
            if (!is_div) begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end else if (div_zero) begin
              hi <= acc_hi;
              lo <= acc_lo;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
            done  <= 1'b1;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Directed bench for hilo_md_ctrl: mult/div results, latency, divide by zero, moves,
// hazard stall, cancel and asynchronous reset.
module tb_hilo_md_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue;
  logic        mult_f, multu_f, div_f, divu_f, mthi_f, mtlo_f, mfhi_f, mflo_f;
  logic [31:0] rs, rt;
  logic        cancel;
  logic [31:0] hi, lo, mf_data;
  logic        busy, stall, done;

  int vectors = 0;
  int miscompares = 0;
  int n;
  int stalls;

  localparam logic [7:0] F_MULT  = 8'h80;
  localparam logic [7:0] F_MULTU = 8'h40;
  localparam logic [7:0] F_DIV   = 8'h20;
  localparam logic [7:0] F_DIVU  = 8'h10;
  localparam logic [7:0] F_MTHI  = 8'h08;
  localparam logic [7:0] F_MTLO  = 8'h04;
  localparam logic [7:0] F_MFHI  = 8'h02;
  localparam logic [7:0] F_MFLO  = 8'h01;

  hilo_md_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .issue(issue),
    .mult_instrc(mult_f), .multu_instrc(multu_f), .div_instrc(div_f), .divu_instrc(divu_f),
    .mthi_instrc(mthi_f), .mtlo_instrc(mtlo_f), .mfhi_instrc(mfhi_f), .mflo_instrc(mflo_f),
    .rs_data(rs), .rt_data(rt), .cancel(cancel),
    .hi(hi), .lo(lo), .mf_data(mf_data), .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic [7:0] f);
    {mult_f, multu_f, div_f, divu_f, mthi_f, mtlo_f, mfhi_f, mflo_f} = f;
  endtask

  task automatic start_op(input logic [7:0] f, input logic [31:0] a, input logic [31:0] b);
    set_flags(f);
    rs = a;
    rt = b;
    issue = 1'b1;
    tick();
    issue = 1'b0;
    set_flags(8'h00);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic run_md(input string tag, input logic [7:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    start_op(f, a, b);
    wait_idle(cyc);
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'd33);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    tick();
    chk({tag, "_done_clear"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    issue = 1'b0;
    cancel = 1'b0;
    rs = '0;
    rt = '0;
    set_flags(8'h00);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    #20 rst_n = 1'b1;
    tick();

    run_md("mult_neg", F_MULT,  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_md("multu",    F_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
    run_md("div_neg",  F_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu",     F_DIVU,  32'd7,        32'd2, 32'd1,        32'd3);
    run_md("div_wrap", F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    run_md("divu_zero", F_DIVU, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF);

    // mthi writes on the next edge with no busy time
    set_flags(F_MTHI);
    rs = 32'hDEADBEEF;
    issue = 1'b1;
    chk("mthi_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    set_flags(F_MFHI);
    #1;
    chk("mfhi_data", mf_data, 32'hDEADBEEF);
    chk("mfhi_stall", {31'd0, stall}, 32'd0);
    tick();
    issue = 1'b0;
    set_flags(8'h00);

    // mflo held behind a multiply stalls for every busy cycle
    start_op(F_MULT, 32'd5, 32'd6);
    set_flags(F_MFLO);
    issue = 1'b1;
    n = 0;
    stalls = 0;
    while (busy === 1'b1 && n < 100) begin
      if (stall === 1'b1) stalls++;
      n++;
      tick();
    end
    chk("haz_busy_cycles", 32'(n), 32'd33);
    chk("haz_stall_cycles", 32'(stalls), 32'd33);
    chk("haz_stall_release", {31'd0, stall}, 32'd0);
    chk("haz_mf_data", mf_data, 32'd30);
    chk("haz_hi", hi, 32'd0);
    tick();
    issue = 1'b0;
    set_flags(8'h00);

    // cancel mid-divide leaves HI/LO untouched
    start_op(F_MTHI, 32'd1, 32'd0);
    start_op(F_MTLO, 32'd2, 32'd0);
    chk("pre_cancel_hi", hi, 32'd1);
    chk("pre_cancel_lo", lo, 32'd2);
    start_op(F_DIV, 32'd100, 32'd7);
    issue = 1'b1;
    #1;
    chk("nonhilo_stall", {31'd0, stall}, 32'd0);
    issue = 1'b0;
    repeat (9) tick();
    chk("cancel_busy_before", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    chk("cancel_hi", hi, 32'd1);
    chk("cancel_lo", lo, 32'd2);
    chk("cancel_done", {31'd0, done}, 32'd0);
    n = 0;
    repeat (30) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) n++;
    end
    chk("cancel_no_late_done", 32'(n), 32'd0);

    // cancel also suppresses a same-cycle mthi
    set_flags(F_MTHI);
    rs = 32'd55;
    issue = 1'b1;
    cancel = 1'b1;
    tick();
    issue = 1'b0;
    cancel = 1'b0;
    set_flags(8'h00);
    chk("cancel_mthi_hi", hi, 32'd1);

    // asynchronous reset mid-multiply, checked between clock edges
    start_op(F_MULT, 32'd5, 32'd6);
    repeat (4) tick();
    chk("mid_mult_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Sequencer for the multiply/divide resource and the HI/LO register pair of the CPU54 core.
- Accepts decoded mult/multu/div/divu/mthi/mtlo/mfhi/mflo flags and operands from the execute stage.
- Runs a 32-step iterative shift-add multiply or a 32-step restoring divide, then applies sign fixup and commits HI/LO.
- Drives a stall so the pipeline holds any HI/LO-dependent instruction until the result is committed.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue  in  1  instruction in execute stage is valid.
- mult_instrc  in  1  signed multiply.
- multu_instrc  in  1  unsigned multiply.
- div_instrc  in  1  signed divide.
- divu_instrc  in  1  unsigned divide.
- mthi_instrc  in  1  write HI from rs_data.
- mtlo_instrc  in  1  write LO from rs_data.
- mfhi_instrc  in  1  read HI.
- mflo_instrc  in  1  read LO.
- rs_data  in  WIDTH  operand A / dividend / mt source.
- rt_data  in  WIDTH  operand B / divisor.
- cancel  in  1  exception flush; aborts an in-flight operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- mf_data  out  WIDTH  hi when mfhi_instrc, lo when mflo_instrc, else 0 (combinational).
- busy  out  1  operation in flight.
- stall  out  1  hold the execute stage.
- done  out  1  one-cycle pulse after HI/LO commit from mult/div.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=lo=0; busy=0; done=0; counter=0; internal accumulators=0. Takes effect immediately, including mid-operation.
- States:
  - IDLE: busy=0.
  - MUL, DIV: busy=1; one iteration per cycle; counter loaded with WIDTH and decremented each cycle; at counter==1 go to SIGN.
  - SIGN: busy=1; apply fixup and commit HI/LO on the exiting edge; go to IDLE; done=1 for the following cycle.
- Start, in IDLE with issue=1:
  - Flag priority when more than one is set: mult > multu > div > divu > mthi > mtlo.
  - Operand capture: magnitudes of rs_data/rt_data for the signed ops; raw values for the unsigned ops. Sign flags are latched.
- Latency: the start edge is T0. busy is high from T0+1 through T0+WIDTH+1. HI/LO are updated at edge T0+WIDTH+1. done is high for the cycle after that edge.
- Multiply: 2*WIDTH-bit product.
  - HI=product[2W-1:W], LO=product[W-1:0].
  - Signed: negate the 2W-bit product if the operand signs differ.
- Divide: LO=quotient, HI=remainder.
  - Signed: negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0 (natural wrap, no trap).
- Divide by zero (div and divu): runs the full WIDTH cycles, then commits HI=rs_data as captured and LO=all ones. Sign fixup is skipped.
- mthi/mtlo in IDLE: hi or lo is written with rs_data on the next edge, zero extra latency; busy stays 0.
- stall = issue & busy & (any of the eight flags).
  - The stalled instruction is re-presented and taken on the first cycle busy=0.
  - mfhi/mflo in the cycle immediately after commit see the new value.
  - Non-HI/LO instructions never stall.
- Issue while busy starts nothing.
- cancel=1:
  - In MUL/DIV/SIGN: return to IDLE next edge; hi/lo unchanged; no done.
  - Also suppresses a start, and any mthi/mtlo write, in the same cycle.
- cancel while in IDLE with issue=0: no effect.
- Only mult/div/mthi/mtlo modify hi/lo.

Test Plan:
- **Multiply:** mult, rs=0xFFFFFFFE, rt=3 → busy for 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done pulse. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- **Divide:**
  - div, rs=0xFFFFFFF9, rt=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu, rs=7, rt=2 → LO=3, HI=1.
  - div, rs=0x80000000, rt=0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** divu, rs=0x12345678, rt=0 → after 33 cycles HI=0x12345678, LO=0xFFFFFFFF.
- **Move to/from HI/LO:**
  - mthi with rs=0xDEADBEEF → hi=0xDEADBEEF next edge, busy stays 0.
  - mfhi next cycle → mf_data=0xDEADBEEF, stall=0.
- **Hazard stall:** mult 5×6, then hold mflo with issue=1 → stall=1 for all busy cycles; in the first cycle stall=0, mf_data=30.
- **Abort paths:**
  - cancel at cycle 10 of a div with prior HI=1, LO=2 → IDLE next edge, hi=1, lo=2, no done.
  - rst_n=0 mid-mult → hi=lo=0 and busy=0 immediately, without a clock edge.
